pc_gen: RTL
===========

# pc_gen

Parametrised program-counter generator for the instruction-fetch stage. It produces the fetch address `pc` and the fetch enable `ce` for instruction ROM/cache. It supports pipeline stall, branch/jump redirect and exception flush, with a one-entry buffer that holds a redirect arriving during a stall. It sits between the pipeline control unit and the instruction memory interface, and feeds `pc` into the IF/ID register.

## Interface
Parameters:
- `ADDR_W`, 32: width of `pc` and all target addresses.
- `RESET_VEC`, 0: value of `pc` during and after reset; this is the first fetched address.
- `INC`, 4: sequential increment added each non-stalled cycle.
- `ALIGN`, 2: number of low address bits that must be zero; `ALIGN` = 0 disables the alignment check.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `stall`  in  1  hold `pc` this cycle (from pipeline control).
- `branch_flag`  in  1  redirect request from decode/execute.
- `branch_target`  in  ADDR_W  redirect address, valid with `branch_flag`.
- `flush`  in  1  exception/eret flush.
- `flush_pc`  in  ADDR_W  handler/return address, valid with `flush`.
- `pc`  out  ADDR_W  current fetch address (registered).
- `ce`  out  1  instruction memory chip enable (registered).
- `misalign`  out  1  one-cycle pulse when a loaded target had nonzero low `ALIGN` bits.
- `pend_valid`  out  1  a buffered redirect is waiting for stall release.

## Operation
- FSM states:
  - IDLE: post-reset, `ce`=0.
  - RUN: fetching.
  - STALL: `stall` seen, `pc` held.
- Reset while `rst`=0, from any state and mid-redirect:
  - `pc`=RESET_VEC, `ce`=0, `misalign`=0, `pend_valid`=0, state IDLE.
  - The pending buffer contents are don't-care.
- IDLE: the first edge with `rst`=1 sets `ce`=1 and moves to RUN. `pc` stays RESET_VEC, so RESET_VEC is fetched first. All other inputs are ignored in IDLE.
- RUN/STALL next-pc selection, highest priority first:
  1. `flush`=1: `pc`<=`flush_pc`, clear pending, state RUN. `flush` overrides `stall`.
  2. `stall`=1: `pc` held, state STALL. If `branch_flag`=1, capture `branch_target` into the pending buffer and set `pend_valid`. A later capture overwrites an earlier one (newest wins).
  3. `stall`=0 and `branch_flag`=1: `pc`<=`branch_target`, clear pending, state RUN. A live branch beats a buffered one.
  4. `stall`=0 and `pend_valid`=1: `pc`<=pending target, clear `pend_valid`, state RUN.
  5. Otherwise: `pc`<=`pc`+INC, modulo 2^ADDR_W, so it wraps silently from all-ones.
- Alignment, when `ALIGN`>0:
  - Every loaded target (flush, branch or pending) has its low `ALIGN` bits forced to 0.
  - If any forced bit was 1, `misalign`=1 in the cycle the new `pc` is visible.
  - The alignment check is applied when the target is loaded into `pc`, not when it is captured.
  - A sequential increment never raises `misalign`.
- `ce` stays 1 in RUN and STALL. During a stall the same address is re-fetched.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Redirect latency is 1 cycle: a `branch_flag` or `flush` sampled at edge n gives `pc`=target after edge n.
- Buffered redirect: the `pc` update happens at the first edge where `stall`=0, so the target appears 1 cycle after stall release.
- `misalign` lasts exactly one cycle unless the following load is also misaligned.
- `pend_valid` rises 1 cycle after the capturing edge and falls on the edge that consumes or flushes the buffer.
- Reset deassertion: IDLE for exactly one edge, then `ce`=1. The first increment happens on the second edge after release.

## Test plan
- Reset and increment:
  - Stimulus: ADDR_W=32, RESET_VEC=0xBFC00000, release `rst`, run 4 cycles.
  - Required: `ce`=0 then 1; `pc` = 0xBFC00000, 0xBFC00000, 0xBFC00004, 0xBFC00008.
  - Asserting `rst`=0 mid-run gives `pc`=0xBFC00000 and `ce`=0 with no clock edge.
- Branch:
  - Stimulus: at `pc`=0x10, pulse `branch_flag` with `branch_target`=0x200.
  - Required: next `pc`=0x200, then 0x204; `misalign`=0.
- Stall with buffered branch:
  - Stimulus: `stall`=1 for 3 cycles at `pc`=0x40, `branch_flag` pulsed with 0x80 in the 2nd stall cycle.
  - Required: `pc` holds 0x40; `pend_valid`=1; after release `pc`=0x80, then 0x84; `pend_valid`=0.
- Flush priority:
  - Stimulus: `stall`=1, `branch_flag`=1 (target 0x300), `flush`=1 (`flush_pc`=0x180) in the same cycle.
  - Required: `pc`=0x180, `pend_valid`=0, state RUN.
- Alignment and wrap:
  - Stimulus: `branch_target`=0x1003 with ALIGN=2.
  - Required: `pc`=0x1000 with a 1-cycle `misalign` pulse.
  - Separately, ADDR_W=8, INC=4, start at 0xFC: next `pc`=0x00.
- Overwrite:
  - Stimulus: two branches (0x500, then 0x600) during one stall.
  - Required: after release `pc`=0x600.

Source files
------------

// File: rtl/pc_gen.sv
// Program-counter generator for the instruction-fetch stage: sequential fetch,
// stall hold, branch/flush redirect and a one-entry buffer for redirects seen during a stall.
module pc_gen #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                INC       = 4,
    parameter int                ALIGN     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              misalign,
    output logic              pend_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ONE        = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ALIGN_MASK = (ALIGN == 0) ? '0 : ((ONE << ALIGN) - ONE);
    localparam logic [ADDR_W-1:0] INC_W      = ADDR_W'(INC);

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              ce_q;
    logic              misalign_q;
    logic              pendValid_q;
    logic [ADDR_W-1:0] pendTarget_q;

    logic [ADDR_W-1:0] loadAddr;
    logic [ADDR_W-1:0] alignedAddr_d;
    logic              misalign_d;

    // Redirect source in priority order; only meaningful when the FSM decides to load.
    always_comb begin
        loadAddr = pendTarget_q;
        if (flush) begin
            loadAddr = flush_pc;
        end else if (branch_flag) begin
            loadAddr = branch_target;
        end
        alignedAddr_d = loadAddr & ~ALIGN_MASK;
        misalign_d    = |(loadAddr & ALIGN_MASK);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_VEC;
            ce_q         <= 1'b0;
            misalign_q   <= 1'b0;
            pendValid_q  <= 1'b0;
            pendTarget_q <= '0;
        end else begin
            misalign_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    ce_q    <= 1'b1;
                    state_q <= RUN;
                end
                RUN, STALL: begin
                    if (flush) begin
                        pc_q        <= alignedAddr_d;
                        misalign_q  <= misalign_d;
                        pendValid_q <= 1'b0;
                        state_q     <= RUN;
                    end else if (stall) begin
                        state_q <= STALL;
                        if (branch_flag) begin
                            pendTarget_q <= branch_target;
                            pendValid_q  <= 1'b1;
                        end
                    end else if (branch_flag || pendValid_q) begin
                        pc_q        <= alignedAddr_d;
                        misalign_q  <= misalign_d;
                        pendValid_q <= 1'b0;
                        state_q     <= RUN;
                    end else begin
                        pc_q    <= pc_q + INC_W;
                        state_q <= RUN;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ce_q    <= 1'b0;
                end
            endcase
        end
    end

    assign pc         = pc_q;
    assign ce         = ce_q;
    assign misalign   = misalign_q;
    assign pend_valid = pendValid_q;

endmodule
